// File: rtl/pio_in_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pio_in_pkg
// Description : Shared register addresses and edge-type encodings for the
//               edge-capturing input PIO.
// Revision    : 1.0 - initial release
// ============================================================================
package pio_in_pkg;

   // Word addresses of the slave register map
   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_DEBOUNCE = 3'd1;
   localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
   localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
   localparam logic [2:0] ADDR_PENDING  = 3'd4;

   // EDGE_TYPE parameter encodings
   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage : pio_in_pkg
`default_nettype wire

// File: rtl/pio_in_sync_debounce.sv
`default_nettype none
// ============================================================================
// Module      : pio_in_sync_debounce
// Description : One input bit: multi-flop synchroniser, counting debouncer
//               and a one-cycle delayed copy of the debounced level.
// Revision    : 1.0 - initial release
// ============================================================================
module pio_in_sync_debounce
   import pio_in_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             raw,
   input  logic [CNT_W-1:0] limit,
   output logic             stable,
   output logic             stable_d
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_stable;
   logic                   r_stable_d;
   logic                   w_sync;
   logic [CNT_W-1:0]       w_last;

   assign w_sync = r_sync[SYNC_STAGES-1];

   // A limit of zero behaves as one, so the terminal count is limit-1 floored at 0.
   assign w_last = (limit == '0) ? '0 : (limit - CNT_W'(1));

   // Shift the raw asynchronous input through the synchroniser chain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_sync <= '0;
      else          r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
   end

   // Accept a new level only after it has differed for L consecutive cycles;
   // >= lets a shortened limit take effect on a count already in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt    <= '0;
         r_stable <= 1'b0;
      end else if (w_sync == r_stable) begin
         r_cnt <= '0;
      end else if (r_cnt >= w_last) begin
         r_stable <= w_sync;
         r_cnt    <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Delayed copy of the debounced level for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_stable_d <= 1'b0;
      else          r_stable_d <= r_stable;
   end

   assign stable   = r_stable;
   assign stable_d = r_stable_d;

endmodule : pio_in_sync_debounce
`default_nettype wire

// File: rtl/pio_in_edge_irq.sv
`default_nettype none
// ============================================================================
// Module      : pio_in_edge_irq
// Description : Avalon-MM input PIO with per-bit synchroniser and debounce,
//               selectable edge capture (write-1-to-clear) and masked IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
module pio_in_edge_irq
   import pio_in_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16,
   parameter int EDGE_TYPE   = 0,
   parameter int DB_RESET    = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq,
   output logic [31:0]      readdata
);

   logic             w_wr;
   logic [WIDTH-1:0] w_stable;
   logic [WIDTH-1:0] w_stable_d;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] w_clr;
   logic [31:0]      w_rdata;
   logic             w_unused_wdata;

   logic [CNT_W-1:0] r_db_limit;
   logic [WIDTH-1:0] r_irq_mask;
   logic [WIDTH-1:0] r_edge_capture;
   logic [31:0]      r_readdata;

   assign w_wr           = chipselect & ~write_n;
   assign w_unused_wdata = ^writedata;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         pio_in_sync_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W)
         ) u_sync_db (
            .clk      (clk),
            .reset_n  (reset_n),
            .raw      (in_port[i]),
            .limit    (r_db_limit),
            .stable   (w_stable[i]),
            .stable_d (w_stable_d[i])
         );
      end
   endgenerate

   assign w_rise = w_stable & ~w_stable_d;
   assign w_fall = ~w_stable & w_stable_d;

   // Pick which transitions are captured.
   always_comb begin
      w_edge = w_rise;
      if (EDGE_TYPE == EDGE_FALL)     w_edge = w_fall;
      else if (EDGE_TYPE == EDGE_ANY) w_edge = w_rise | w_fall;
   end

   assign w_clr = (w_wr && (address == ADDR_EDGE_CAP)) ? writedata[WIDTH-1:0] : '0;

   // Writable configuration registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_db_limit <= CNT_W'(DB_RESET);
         r_irq_mask <= '0;
      end else if (w_wr) begin
         if (address == ADDR_DEBOUNCE) r_db_limit <= writedata[CNT_W-1:0];
         if (address == ADDR_IRQ_MASK) r_irq_mask <= writedata[WIDTH-1:0];
      end
   end

   // Edge capture: a new edge wins over a simultaneous clear so none is lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_edge_capture <= '0;
      else          r_edge_capture <= w_edge | (r_edge_capture & ~w_clr);
   end

   // Read mux, zero-extended to the bus width.
   always_comb begin
      w_rdata = '0;
      case (address)
         ADDR_DATA:     w_rdata[WIDTH-1:0] = w_stable;
         ADDR_DEBOUNCE: w_rdata[CNT_W-1:0] = r_db_limit;
         ADDR_IRQ_MASK: w_rdata[WIDTH-1:0] = r_irq_mask;
         ADDR_EDGE_CAP: w_rdata[WIDTH-1:0] = r_edge_capture;
         ADDR_PENDING:  w_rdata[WIDTH-1:0] = r_edge_capture & r_irq_mask;
         default:       w_rdata = '0;
      endcase
   end

   // Registered read data, refreshed every cycle regardless of chipselect.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_readdata <= '0;
      else          r_readdata <= w_rdata;
   end

   assign readdata = r_readdata;
   assign irq      = |(r_edge_capture & r_irq_mask);

endmodule : pio_in_edge_irq
`default_nettype wire

// File: tb/tb_pio_in_edge_irq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pio_in_edge_irq
// Description : Directed self-checking bench; a rising-edge and an any-edge
//               instance share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_in_edge_irq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [7:0]  in_port;
   logic        irq;
   logic [31:0] readdata;
   logic        irq_any;
   logic [31:0] readdata_any;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pio_in_edge_irq #(
      .WIDTH(8), .SYNC_STAGES(2), .CNT_W(16), .EDGE_TYPE(0), .DB_RESET(0)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .irq(irq), .readdata(readdata)
   );

   pio_in_edge_irq #(
      .WIDTH(8), .SYNC_STAGES(2), .CNT_W(16), .EDGE_TYPE(2), .DB_RESET(0)
   ) dut_any (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .irq(irq_any), .readdata(readdata_any)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic bus_read(input logic [2:0] a);
      address = a;
      tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
      writedata = '0; in_port = '0;
      repeat (3) tick();
      checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got 0x%0h expected 0x0", readdata); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
      reset_n = 1'b1;
      for (int a = 0; a < 5; a++) begin
         bus_read(3'(a));
         checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_reg%0d: got 0x%0h expected 0x0", a, readdata); end
      end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq_after: got %b expected 0", irq); end
      bus_write(3'd1, 32'd3);
      checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL read_latency_old: got 0x%0h expected 0x0", readdata); end
      tick();
      checks++; if (readdata !== 32'h3) begin errors++; $display("FAIL read_latency_new: got 0x%0h expected 0x3", readdata); end
   endtask

   task automatic test_rise_latency();
      bus_write(3'd2, 32'h01);
      address    = 3'd0;
      in_port[0] = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 5) begin
            checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL latency_early_data: got 0x%0h expected 0x0", readdata); end
            checks++; if (irq !== 1'b0) begin errors++; $display("FAIL latency_early_irq: got %b expected 0", irq); end
         end
         if (k == 6) begin
            checks++; if (readdata !== 32'h1) begin errors++; $display("FAIL latency_data: got 0x%0h expected 0x1", readdata); end
            checks++; if (irq !== 1'b1) begin errors++; $display("FAIL latency_irq: got %b expected 1", irq); end
         end
      end
      bus_read(3'd3);
      checks++; if (readdata !== 32'h1) begin errors++; $display("FAIL latency_cap: got 0x%0h expected 0x1", readdata); end
      bus_write(3'd3, 32'h01);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b expected 0", irq); end
   endtask

   task automatic test_glitch();
      bus_write(3'd1, 32'd4);
      bus_write(3'd2, 32'hFF);
      in_port[2] = 1'b1;
      repeat (3) tick();
      in_port[2] = 1'b0;
      repeat (10) tick();
      bus_read(3'd0);
      checks++; if (readdata !== 32'h1) begin errors++; $display("FAIL glitch_data: got 0x%0h expected 0x1", readdata); end
      bus_read(3'd3);
      checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL glitch_cap: got 0x%0h expected 0x0", readdata); end
      checks++; if (irq_any !== 1'b0) begin errors++; $display("FAIL glitch_irq: got %b expected 0", irq_any); end
   endtask

   task automatic test_any_edge();
      in_port[1] = 1'b1;
      repeat (12) tick();
      bus_read(3'd3);
      checks++; if (readdata_any !== 32'h2) begin errors++; $display("FAIL any_rise_cap: got 0x%0h expected 0x2", readdata_any); end
      checks++; if (irq_any !== 1'b1) begin errors++; $display("FAIL any_rise_irq: got %b expected 1", irq_any); end
      bus_write(3'd3, 32'h02);
      checks++; if (irq_any !== 1'b0) begin errors++; $display("FAIL any_clear_irq: got %b expected 0", irq_any); end
      bus_read(3'd3);
      checks++; if (readdata_any !== 32'h0) begin errors++; $display("FAIL any_clear_cap: got 0x%0h expected 0x0", readdata_any); end
      in_port[1] = 1'b0;
      repeat (12) tick();
      bus_read(3'd3);
      checks++; if (readdata_any !== 32'h2) begin errors++; $display("FAIL any_fall_cap: got 0x%0h expected 0x2", readdata_any); end
      checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL rise_ignores_fall: got 0x%0h expected 0x0", readdata); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rise_fall_irq: got %b expected 0", irq); end
      bus_write(3'd3, 32'h02);
   endtask

   task automatic test_set_wins_clear();
      in_port[0] = 1'b0;
      repeat (12) tick();
      bus_write(3'd3, 32'hFF);
      bus_read(3'd3);
      checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL swc_pre_cap: got 0x%0h expected 0x0", readdata); end
      in_port[0] = 1'b1;
      repeat (6) tick();
      bus_write(3'd3, 32'h01);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL swc_irq: got %b expected 1", irq); end
      bus_read(3'd3);
      checks++; if (readdata !== 32'h1) begin errors++; $display("FAIL swc_cap: got 0x%0h expected 0x1", readdata); end
   endtask

   task automatic test_pending_mask();
      in_port[3] = 1'b1;
      repeat (12) tick();
      bus_write(3'd2, 32'h09);
      bus_read(3'd4);
      checks++; if (readdata !== 32'h9) begin errors++; $display("FAIL pending_09: got 0x%0h expected 0x9", readdata); end
      bus_write(3'd2, 32'h08);
      bus_read(3'd4);
      checks++; if (readdata !== 32'h8) begin errors++; $display("FAIL pending_08: got 0x%0h expected 0x8", readdata); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pending_irq: got %b expected 1", irq); end
      bus_write(3'd3, 32'h08);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL masked_irq: got %b expected 0", irq); end
      bus_read(3'd3);
      checks++; if (readdata !== 32'h1) begin errors++; $display("FAIL masked_cap: got 0x%0h expected 0x1", readdata); end
      bus_write(3'd5, 32'hFFFF_FFFF);
      bus_read(3'd5);
      checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL unused_addr: got 0x%0h expected 0x0", readdata); end
      bus_read(3'd1);
      checks++; if (readdata !== 32'h4) begin errors++; $display("FAIL unused_no_effect: got 0x%0h expected 0x4", readdata); end
      bus_write(3'd2, 32'hFFFF_FF00);
      bus_read(3'd2);
      checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL mask_upper_bits: got 0x%0h expected 0x0", readdata); end
      bus_write(3'd1, 32'hABCD_0007);
      bus_read(3'd1);
      checks++; if (readdata !== 32'h7) begin errors++; $display("FAIL db_upper_bits: got 0x%0h expected 0x7", readdata); end
   endtask

   task automatic test_reset_mid();
      bus_write(3'd1, 32'd4);
      bus_write(3'd2, 32'hFF);
      address    = 3'd1;
      in_port[4] = 1'b1;
      repeat (3) tick();
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b expected 1", irq); end
      #3;
      reset_n = 1'b0;
      in_port = '0;
      #1;
      checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL async_reset_rd: got 0x%0h expected 0x0", readdata); end
      checks++; if (irq !== 1'b0 || irq_any !== 1'b0) begin errors++; $display("FAIL async_reset_irq: got %b%b expected 00", irq, irq_any); end
      tick();
      tick();
      reset_n = 1'b1;
      for (int a = 0; a < 5; a++) begin
         bus_read(3'(a));
         checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL midreset_reg%0d: got 0x%0h expected 0x0", a, readdata); end
      end
   endtask

   task automatic test_debounce_shrink();
      bus_write(3'd1, 32'd10);
      in_port[5] = 1'b1;
      repeat (6) tick();
      bus_write(3'd1, 32'd2);
      address = 3'd0;
      tick();
      tick();
      checks++; if (readdata !== 32'h20) begin errors++; $display("FAIL db_shrink: got 0x%0h expected 0x20", readdata); end
   endtask

   initial begin
      test_reset();
      test_rise_latency();
      test_glitch();
      test_any_edge();
      test_set_wins_clear();
      test_pending_mask();
      test_reset_mid();
      test_debounce_shrink();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got timeout expected completion");
      $fatal(1);
   end

endmodule : tb_pio_in_edge_irq
`default_nettype wire
